// File: rtl/nco_pkg.sv
// ---------------------------------------------------------------------------
// nco_pkg
// Shared types and constants for the NCO LUT driver.
//   state_t      : sequencer states (IDLE, SIN, COS)
//   tag_t        : marker travelling alongside each LUT address
//   LUT_LAT      : cycles from lut_a to the matching lut_d
//   quarter_turn : address offset for a 90-degree phase shift
// ---------------------------------------------------------------------------
package nco_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SIN  = 2'd1,
    COS  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_SIN  = 2'd1,
    TAG_COS  = 2'd2
  } tag_t;

  localparam int LUT_LAT = 2;

  // A quarter of the full LUT address circle: 2^(a-2).
  function automatic int quarter_turn(input int a);
    return 1 << (a - 2);
  endfunction

endpackage

// File: rtl/nco_phase_acc.sv
// ---------------------------------------------------------------------------
// nco_phase_acc
// Phase accumulator with a single-slot frequency mailbox.
//   clk, rst      : clock, synchronous active-high reset
//   freq          : offered phase increment
//   freq_valid    : freq is offered
//   freq_ready    : mailbox empty, offer will be taken
//   advance       : this cycle ends a COS slot, step the phase
//   idle          : sequencer is idle, a waiting freq may be applied now
//   phase_top_nxt : top address bits of the phase value after this edge
// A new frequency only takes effect at a sample boundary (or immediately
// while idle) so that a sin/cos pair is never built from two phases.
// ---------------------------------------------------------------------------
module nco_phase_acc #(
  parameter int psz = 32,
  parameter int asz = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [psz-1:0] freq,
  input  logic           freq_valid,
  output logic           freq_ready,
  input  logic           advance,
  input  logic           idle,
  output logic [asz-1:0] phase_top_nxt
);

  logic [psz-1:0] phase;
  logic [psz-1:0] phase_nxt;
  logic [psz-1:0] freq_hold;
  logic [psz-1:0] freq_eff;
  logic           pending;
  logic           accept;
  logic           apply;

  assign freq_ready = ~pending;
  assign accept     = freq_valid & ~pending;
  assign apply      = pending & (advance | idle);

  // The step uses the increment in force during the sample just finished;
  // a newly applied value governs the following step.
  assign phase_nxt     = advance ? phase + freq_eff : phase;
  assign phase_top_nxt = phase_nxt[psz-1 -: asz];

  // NOTE: sequential state is written with <= so every register samples the
  // pre-edge values; blocking = here would make ordering within the block
  // change the hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase     <= '0;
      freq_hold <= '0;
      freq_eff  <= '0;
      pending   <= 1'b0;
    end else begin
      phase <= phase_nxt;
      if (accept) freq_hold <= freq;
      // freq_hold on the right is the pre-edge value, so an apply and an
      // accept in one cycle forwards the old value and stores the new one.
      if (apply)  freq_eff  <= freq_hold;
      pending <= accept | (pending & ~apply);
    end
  end

endmodule

// File: rtl/nco_lut_driver.sv
// ---------------------------------------------------------------------------
// nco_lut_driver
// Drives a shared sin/cos lookup table to produce I/Q sample pairs. Each
// sample takes two cycles: a SIN address, then the same address advanced by
// a quarter turn (COS). Data returns LUT_LAT cycles later and is matched to
// its request by a tag pipeline.
//   clk, rst             : clock, synchronous active-high reset
//   en                   : run enable
//   freq / freq_valid    : phase increment offer
//   freq_ready           : increment mailbox empty
//   phase_ofs            : static phase offset added to the address
//   lut_a                : registered LUT address
//   lut_d                : LUT data, LUT_LAT cycles behind lut_a
//   sin_out, cos_out     : I/Q sample pair, held between strobes
//   iq_valid             : one-cycle strobe for a new pair
// ---------------------------------------------------------------------------
module nco_lut_driver
  import nco_pkg::*;
#(
  parameter int asz = 10,
  parameter int dsz = 14,
  parameter int psz = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [psz-1:0]        freq,
  input  logic                  freq_valid,
  output logic                  freq_ready,
  input  logic [asz-1:0]        phase_ofs,
  output logic [asz-1:0]        lut_a,
  input  logic signed [dsz-1:0] lut_d,
  output logic signed [dsz-1:0] sin_out,
  output logic signed [dsz-1:0] cos_out,
  output logic                  iq_valid
);

  localparam logic [asz-1:0] QTR = asz'(quarter_turn(asz));

  state_t                state;
  tag_t                  cur_tag;
  tag_t                  tag_q [LUT_LAT];
  logic [asz-1:0]        phase_top_nxt;
  logic [asz-1:0]        sin_addr_nxt;
  logic signed [dsz-1:0] sin_hold;

  nco_phase_acc #(
    .psz(psz),
    .asz(asz)
  ) u_phase_acc (
    .clk          (clk),
    .rst          (rst),
    .freq         (freq),
    .freq_valid   (freq_valid),
    .freq_ready   (freq_ready),
    .advance      (state == COS),
    .idle         (state == IDLE),
    .phase_top_nxt(phase_top_nxt)
  );

  // The SIN address is formed from the phase as it will be after this edge,
  // so a COS->SIN transition already sees the freshly stepped phase.
  assign sin_addr_nxt = phase_top_nxt + phase_ofs;

  // The state register is aligned with lut_a, so it serves as the tag of the
  // address currently on the bus.
  // NOTE: every output of an always_comb gets a default before the case so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cur_tag = TAG_NONE;
    case (state)
      SIN:     cur_tag = TAG_SIN;
      COS:     cur_tag = TAG_COS;
      default: cur_tag = TAG_NONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lut_a    <= '0;
      sin_hold <= '0;
      sin_out  <= '0;
      cos_out  <= '0;
      iq_valid <= 1'b0;
      // NOTE: the tag pipeline is reset element by element; unlike a data
      // memory its contents must be cleared so stale requests never emerge.
      for (int i = 0; i < LUT_LAT; i++) tag_q[i] <= TAG_NONE;
    end else begin
      // Sequencer: a started pair always completes its COS half.
      case (state)
        IDLE: begin
          if (en) begin
            state <= SIN;
            lut_a <= sin_addr_nxt;
          end
        end
        SIN: begin
          state <= COS;
          lut_a <= lut_a + QTR;
        end
        COS: begin
          if (en) begin
            state <= SIN;
            lut_a <= sin_addr_nxt;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Tag pipeline: tag_q[LUT_LAT-1] describes the lut_d of this cycle.
      tag_q[0] <= cur_tag;
      for (int i = 1; i < LUT_LAT; i++) tag_q[i] <= tag_q[i-1];

      if (tag_q[LUT_LAT-1] == TAG_SIN) sin_hold <= lut_d;

      iq_valid <= (tag_q[LUT_LAT-1] == TAG_COS);
      if (tag_q[LUT_LAT-1] == TAG_COS) begin
        sin_out <= sin_hold;
        cos_out <= lut_d;
      end
    end
  end

endmodule

// File: tb/tb_nco_lut_driver.sv
// ---------------------------------------------------------------------------
// tb_nco_lut_driver
// Directed stimulus with a scoreboard: expected I/Q pairs are queued when a
// test starts, and a monitor compares every iq_valid strobe against the head
// of the queue. The LUT is modelled as a two-stage register returning the
// sign-extended address as data.
// ---------------------------------------------------------------------------
module tb_nco_lut_driver;

  localparam int ASZ = 10;
  localparam int DSZ = 14;
  localparam int PSZ = 32;

  typedef struct {
    int s;
    int c;
  } pair_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  en;
  logic [PSZ-1:0]        freq;
  logic                  freq_valid;
  logic                  freq_ready;
  logic [ASZ-1:0]        phase_ofs;
  logic [ASZ-1:0]        lut_a;
  logic signed [DSZ-1:0] lut_d;
  logic signed [DSZ-1:0] sin_out;
  logic signed [DSZ-1:0] cos_out;
  logic                  iq_valid;

  logic [ASZ-1:0]        lut_p1;

  pair_t exp_q[$];
  pair_t mon_p;
  int    exp_a[$];
  int    n_checks     = 0;
  int    n_fail       = 0;
  int    iq_count     = 0;
  int    cyc          = 0;
  int    first_iq_cyc = -1;
  int    sin_cyc      = 0;
  int    iq_before    = 0;

  nco_lut_driver #(
    .asz(ASZ),
    .dsz(DSZ),
    .psz(PSZ)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .freq      (freq),
    .freq_valid(freq_valid),
    .freq_ready(freq_ready),
    .phase_ofs (phase_ofs),
    .lut_a     (lut_a),
    .lut_d     (lut_d),
    .sin_out   (sin_out),
    .cos_out   (cos_out),
    .iq_valid  (iq_valid)
  );

  always #4 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // LUT model: two register stages, data = sign-extended address.
  always @(posedge clk) begin
    lut_p1 <= lut_a;
    lut_d  <= {{(DSZ-ASZ){lut_p1[ASZ-1]}}, lut_p1};
  end

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest expected pair.
  always @(negedge clk) begin
    if (iq_valid === 1'b1) begin
      iq_count++;
      if (first_iq_cyc < 0) first_iq_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_iq: got iq_valid=1, expected no pair (cycle %0d)", cyc);
      end else begin
        mon_p = exp_q.pop_front();
        check("sin_out", int'(sin_out), mon_p.s);
        check("cos_out", int'(cos_out), mon_p.c);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int s, input int c);
    pair_t p;
    p.s = s;
    p.c = c;
    exp_q.push_back(p);
  endtask

  task automatic reset_dut();
    rst        = 1'b1;
    en         = 1'b0;
    freq_valid = 1'b0;
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  // Offer one increment while idle; it is taken, then applied a cycle later.
  task automatic load_freq(input logic [PSZ-1:0] v);
    freq       = v;
    freq_valid = 1'b1;
    tick();
    freq_valid = 1'b0;
    tick();
  endtask

  // Run with en high for exp_a.size() cycles, checking every address, and
  // drop en during the final (COS) cycle.
  task automatic run_addrs(input string name);
    first_iq_cyc = -1;
    en = 1'b1;
    for (int i = 0; i < exp_a.size(); i++) begin
      tick();
      if (i == 0) sin_cyc = cyc;
      check(name, int'(lut_a), exp_a[i]);
      if (i == exp_a.size() - 1) en = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    repeat (3) tick();
    check({name, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    en         = 1'b0;
    freq       = '0;
    freq_valid = 1'b0;
    phase_ofs  = '0;

    // Reset state.
    tick();
    check("rst_lut_a",      int'(lut_a),      0);
    check("rst_sin_out",    int'(sin_out),    0);
    check("rst_cos_out",    int'(cos_out),    0);
    check("rst_iq_valid",   int'(iq_valid),   0);
    check("rst_freq_ready", int'(freq_ready), 1);
    rst = 1'b0;
    tick();

    // Basic run: +4 address steps, latency and pair contents.
    freq       = 32'h0100_0000;
    freq_valid = 1'b1;
    tick();
    freq_valid = 1'b0;
    check("t1_ready_pending", int'(freq_ready), 0);
    tick();
    check("t1_ready_applied", int'(freq_ready), 1);
    push(0, 256);
    push(4, 260);
    push(8, 264);
    exp_a = '{0, 256, 4, 260, 8, 264};
    run_addrs("t1_lut_a");
    drain("t1");
    check("t1_latency", first_iq_cyc - sin_cyc, 4);

    // Negative step with wrap-around: 0xFF00_0000 is -4 address steps.
    reset_dut();
    load_freq(32'hFF00_0000);
    push(0, 256);
    push(-4, 252);
    push(-8, 248);
    exp_a = '{0, 256, 1020, 252, 1016, 248};
    run_addrs("t2_lut_a");
    drain("t2");

    // Frequency change while running, with the mailbox already occupied.
    reset_dut();
    load_freq(32'h0100_0000);
    push(0, 256);
    push(4, 260);
    push(8, 264);
    push(16, 272);
    push(24, 280);
    exp_a = '{0, 256, 4, 260, 8, 264, 16, 272, 24, 280};
    en = 1'b1;
    for (int i = 0; i < exp_a.size(); i++) begin
      tick();
      check("t3_lut_a", int'(lut_a), exp_a[i]);
      case (i)
        0: begin
          check("t3_ready_c0", int'(freq_ready), 1);
          freq       = 32'h0100_0000;
          freq_valid = 1'b1;
        end
        1: begin
          check("t3_ready_full", int'(freq_ready), 0);
          freq = 32'h0200_0000;
        end
        2: check("t3_ready_freed", int'(freq_ready), 1);
        3: begin
          freq_valid = 1'b0;
          check("t3_ready_full2", int'(freq_ready), 0);
        end
        4: check("t3_ready_freed2", int'(freq_ready), 1);
        default: ;
      endcase
      if (i == exp_a.size() - 1) en = 1'b0;
    end
    drain("t3");

    // en dropped in the SIN cycle: the COS still goes out, one pair results,
    // then the address holds while idle. Phase is now 32, step 8.
    iq_before = iq_count;
    push(32, 288);
    en = 1'b1;
    tick();
    check("t4_lut_a_sin", int'(lut_a), 32);
    en = 1'b0;
    tick();
    check("t4_lut_a_cos", int'(lut_a), 288);
    repeat (3) begin
      tick();
      check("t4_lut_a_hold", int'(lut_a), 288);
    end
    drain("t4");
    check("t4_one_pair", iq_count - iq_before, 1);

    // Reset one cycle after a SIN issue: nothing may emerge. Phase is 40.
    en = 1'b1;
    tick();
    check("t5_lut_a_sin", int'(lut_a), 40);
    en = 1'b0;
    tick();
    rst = 1'b1;
    exp_q.delete();
    iq_before = iq_count;
    tick();
    rst = 1'b0;
    check("t5_lut_a",      int'(lut_a),      0);
    check("t5_sin_out",    int'(sin_out),    0);
    check("t5_cos_out",    int'(cos_out),    0);
    check("t5_iq_valid",   int'(iq_valid),   0);
    check("t5_freq_ready", int'(freq_ready), 1);
    repeat (4) tick();
    check("t5_no_iq", iq_count - iq_before, 0);

    // Maximum phase offset with zero increment: addresses wrap at the
    // quarter turn, data 1023 reads back as -1.
    phase_ofs = 10'd1023;
    push(-1, 255);
    push(-1, 255);
    exp_a = '{1023, 255, 1023, 255};
    run_addrs("t6_lut_a");
    drain("t6");
    check("t6_latency", first_iq_cyc - sin_cyc, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
